// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: FSM encodings, register map, STATUS bit positions, parity helper.
// The optional parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_tx_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int FIFO_DEPTH_DEFAULT   = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int   ADDR_SEL_BIT = 2;
  localparam logic REG_TXDATA   = 1'b0;
  localparam logic REG_STATUS   = 1'b1;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO with wrap-around pointers and an occupancy count.
// Push on full and pop on empty are ignored; simultaneous push and pop keep the count.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == {(AW+1){1'b0}});
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter on the PicoRV32 native bus: TXDATA push port, STATUS poll port.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (11-bit frames).
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        serial_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_TOP = CW'(CLKS_PER_BIT - 1);

  logic [2:0]                    state;
  logic [CW-1:0]                 cnt;
  logic [2:0]                    bit_idx;
  logic [7:0]                    shift;
`ifdef UART_TX_PARITY_EN
  logic                          par;
`endif
  logic [7:0]                    fifo_rdata;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          req;
  logic                          is_status;
  logic                          wr_txdata;
  logic                          push;
  logic                          ack;
  logic                          pop;
  logic                          line;
  logic [31:0]                   status;
  logic                          unused;

  assign unused = ^{mem_instr, mem_wdata[31:8], mem_addr[31:3], mem_addr[1:0], fifo_count};

  // A full-FIFO write stalls here until a pop frees an entry, so the byte is never lost.
  assign req       = enable & mem_valid & ~mem_ready;
  assign is_status = (mem_addr[ADDR_SEL_BIT] == REG_STATUS);
  assign wr_txdata = req & (mem_addr[ADDR_SEL_BIT] == REG_TXDATA) & mem_wstrb[0];
  assign push      = wr_txdata & ~fifo_full;
  assign ack       = req & ~(wr_txdata & fifo_full);
  assign pop       = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & (cnt == {CW{1'b0}})));

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (mem_wdata[7:0]),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    status             = 32'd0;
    status[STAT_BUSY]  = (state != ST_IDLE);
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      mem_ready <= ack;
      mem_rdata <= (ack & is_status & (mem_wstrb == 4'd0)) ? status : 32'd0;
    end
  end

  // Frame sequencer; a pop in STOP chains straight into the next START with no idle gap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cnt     <= {CW{1'b0}};
      bit_idx <= 3'd0;
      shift   <= 8'd0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (pop) begin
      state   <= ST_START;
      cnt     <= CNT_TOP;
      shift   <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
      par     <= even_parity(fifo_rdata);
`endif
    end else if (state != ST_IDLE) begin
      if (cnt != {CW{1'b0}}) begin
        cnt <= cnt - CW'(1);
      end else begin
        cnt <= CNT_TOP;
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            bit_idx <= 3'd0;
          end
          ST_DATA: begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (bit_idx == 3'd7) state <= ST_PARITY;
`else
            if (bit_idx == 3'd7) state <= ST_STOP;
`endif
          end
          ST_PARITY: state <= ST_STOP;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    line = 1'b1;
    case (state)
      ST_START:  line = 1'b0;
      ST_DATA:   line = shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line = par;
`else
      ST_PARITY: line = 1'b1;
`endif
      default:   line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) serial_out <= 1'b1;
    else         serial_out <= line;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-schedule model of the line, FIFO occupancy and ack timing.
// Compile with +define+UART_TX_PARITY_EN to exercise the parity build.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB   = 434;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int L = FB * CPB;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [3:0]  mem_wstrb = 4'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_addr = 32'd0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        serial_out;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_instr  (mem_instr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .serial_out (serial_out)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Each accepted byte owns the line over [start, start+L); it is popped at edge start-1.
  typedef struct { int start; logic [7:0] data; } frame_t;
  frame_t frames[$];

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic model_line(input int c);
    int k;
    foreach (frames[i]) begin
      if (c >= frames[i].start && c < frames[i].start + L) begin
        k = (c - frames[i].start) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return frames[i].data[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^frames[i].data;
`endif
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic int model_occ(input int c);
    int n = 0;
    foreach (frames[i]) if (frames[i].start - 1 > c) n++;
    return n;
  endfunction

  function automatic logic model_busy(input int c);
    foreach (frames[i])
      if (c >= frames[i].start - 1 && c < frames[i].start - 1 + L) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_next_pop(input int c);
    foreach (frames[i]) if (frames[i].start - 1 > c) return frames[i].start - 1;
    return c;
  endfunction

  function automatic int last_end();
    if (frames.size() == 0) return 0;
    return frames[frames.size()-1].start + L;
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      check("line_in_reset", {31'd0, serial_out}, 32'd1);
      check("ready_in_reset", {31'd0, mem_ready}, 32'd0);
    end else begin
      check("serial_line", {31'd0, serial_out}, {31'd0, model_line(cyc)});
    end
  end

  // One bus transfer, started right after a falling edge; ack cycle predicted from model occupancy.
  task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                     output logic [31:0] rd);
    int c, a, exp_ack, occ, n, st;
    bit pushes, is_rd;
    logic [31:0] exp_rd;
    c      = cyc;
    pushes = (addr[2] == 1'b0) && strb[0];
    is_rd  = (strb == 4'd0);
    occ    = model_occ(c);
    exp_ack = c + 1;
    if (pushes && occ >= DEPTH) exp_ack = model_next_pop(c) + 1;
    exp_rd = 32'd0;
    if (addr[2] && is_rd)
      exp_rd = {29'd0, (occ == 0), (occ == DEPTH), model_busy(c)};
    enable = 1'b1; mem_valid = 1'b1; mem_addr = addr; mem_wstrb = strb; mem_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready && n < 3 * L);
    a  = cyc;
    rd = mem_rdata;
    check("ack_cycle", a, exp_ack);
    if (is_rd) check("rdata", mem_rdata, exp_rd);
    if (pushes) begin
      st = exp_ack + 2;
      if (last_end() > st) st = last_end();
      frames.push_back('{start: st, data: wd[7:0]});
    end
    mem_valid = 1'b0; enable = 1'b0; mem_wstrb = 4'd0;
    @(negedge clk);
    check("ready_one_cycle", {31'd0, mem_ready}, 32'd0);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic [10:0] pin41;
    int s, gap;
`ifdef UART_TX_PARITY_EN
    pin41 = 11'b10010000010;
`else
    pin41 = 11'b01010000010;
`endif

    repeat (3) @(negedge clk);
    check("reset_serial", {31'd0, serial_out}, 32'd1);
    check("reset_ready", {31'd0, mem_ready}, 32'd0);
    check("reset_rdata", mem_rdata, 32'd0);
    #2 resetn = 1'b1;
    @(negedge clk);
    bus(32'h4, 4'h0, 32'd0, rd);
    check("status_reset_lit", rd, 32'h4);

    // Single 0x41 frame, sampled at bit centres against literal bits.
    bus(32'h0, 4'h1, 32'h41, rd);
    s = frames[frames.size()-1].start;
    for (int k = 0; k < FB; k++) begin
      wait_cyc(s + k * CPB + CPB / 2);
      check("pin41_bit", {31'd0, serial_out}, {31'd0, pin41[k]});
      if (k == 3) begin
        bus(32'h4, 4'h0, 32'd0, rd);
        check("status_midframe_lit", rd, 32'h5);
      end
    end
    wait_cyc(s + L + 5);
    bus(32'h4, 4'h0, 32'd0, rd);
    check("status_after_frame_lit", rd, 32'h4);

    // Six back-to-back writes: the sixth stalls until the first stop bit ends.
    for (int i = 0; i < 6; i++) begin
      bus(32'h0, 4'h1, {24'd0, 8'($urandom_range(0, 255))}, rd);
      if (i == 4) begin
        bus(32'h4, 4'h0, 32'd0, rd);
        check("status_full_lit", rd, 32'h3);
      end
    end
    wait_cyc(last_end() + 5);
    bus(32'h4, 4'h0, 32'd0, rd);
    check("status_drained_lit", rd, 32'h4);

    // Non-pushing writes: no strobe to TXDATA, and a write to STATUS.
    bus(32'h0, 4'h0, 32'hAA, rd);
    bus(32'h4, 4'hF, 32'h55, rd);
    bus(32'h4, 4'h0, 32'd0, rd);
    check("status_nopush_lit", rd, 32'h4);
    repeat (3 * CPB) @(negedge clk);

    // Reset during data bit 3 of 0x55.
    bus(32'h0, 4'h1, 32'h55, rd);
    s = frames[frames.size()-1].start;
    wait_cyc(s + 4 * CPB + CPB / 2);
    check("bit3_before_abort", {31'd0, serial_out}, 32'd0);
    #2 resetn = 1'b0;
    #1 check("abort_line_high", {31'd0, serial_out}, 32'd1);
    frames.delete();
    repeat (4) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    bus(32'h4, 4'h0, 32'd0, rd);
    check("status_after_abort_lit", rd, 32'h4);
    repeat (3 * CPB) @(negedge clk);

    // Random bytes with random spacing and interleaved STATUS polls.
    for (int i = 0; i < 4; i++) begin
      gap = $urandom_range(0, CPB);
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 1) == 1) bus(32'h4, 4'h0, 32'd0, rd);
      bus(32'h0, 4'h1, {24'd0, 8'($urandom_range(0, 255))}, rd);
    end
    wait_cyc(last_end() + 5);

`ifdef UART_TX_PARITY_EN
    bus(32'h0, 4'h1, 32'h41, rd);
    s = frames[frames.size()-1].start;
    bus(32'h0, 4'h1, 32'h07, rd);
    wait_cyc(s + 9 * CPB + CPB / 2);
    check("parity_41_lit", {31'd0, serial_out}, 32'd0);
    s = frames[frames.size()-1].start;
    wait_cyc(s + 9 * CPB + CPB / 2);
    check("parity_07_lit", {31'd0, serial_out}, 32'd1);
    wait_cyc(last_end() + 5);
`endif

    bus(32'h4, 4'h0, 32'd0, rd);
    check("status_final_lit", rd, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
